// File: rtl/spi_xfer_sched.sv
// rtl/spi_xfer_sched.sv - round-robin scheduler sharing one SPI master engine among requesters
module spi_xfer_sched #(
    parameter int NREQ         = 4,
    parameter int DWIDTH       = 32,
    parameter int NSLAVES      = 4,
    parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
    parameter int TIMEOUT      = 1024,
    localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int TW          = $clog2(TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*S_ADDR_WIDTH-1:0]   req_saddr,
    input  logic [NREQ*DWIDTH-1:0]         req_wdata,
    output logic [NREQ-1:0]                req_ready,
    output logic                           m_start,
    output logic [S_ADDR_WIDTH-1:0]        m_saddr,
    output logic [DWIDTH-1:0]              m_wdata,
    input  logic                           m_done,
    input  logic [DWIDTH-1:0]              m_rdata,
    output logic                           rsp_valid,
    output logic [IW-1:0]                  rsp_id,
    output logic [DWIDTH-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t                    state, state_d;
    logic [IW-1:0]             ptr;
    logic [TW-1:0]             timer;
    logic [IW-1:0]             id_q;
    logic [S_ADDR_WIDTH-1:0]   saddr_q;
    logic [DWIDTH-1:0]         wdata_q;
    logic [DWIDTH-1:0]         rdata_q;
    logic                      err_q;

    logic                      found;
    logic [IW-1:0]             win;
    logic [S_ADDR_WIDTH-1:0]   win_saddr;
    logic [DWIDTH-1:0]         win_wdata;
    logic                      addr_ok;
    logic                      timer_hit;

    assign addr_ok   = int'(saddr_q) < NSLAVES;
    assign timer_hit = (timer == TW'(TIMEOUT - 1));

    // Rotating-priority pick: first requesting index at or above ptr, wrapping around
    always_comb begin
        int j;
        found     = 1'b0;
        win       = '0;
        win_saddr = '0;
        win_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_valid[j]) begin
                found     = 1'b1;
                win       = IW'(j);
                win_saddr = req_saddr[j*S_ADDR_WIDTH +: S_ADDR_WIDTH];
                win_wdata = req_wdata[j*DWIDTH +: DWIDTH];
            end
        end
    end

    // Next-state logic and outputs; everything is forced low while reset is held
    always_comb begin
        state_d   = state;
        req_ready = '0;
        m_start   = 1'b0;
        m_saddr   = '0;
        m_wdata   = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = addr_ok ? WAIT : RESP;
            end
            WAIT: begin
                if (m_done || timer_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            busy = (state != IDLE);
            if (state == IDLE && found) begin
                req_ready = NREQ'(1) << win;
            end
            if (state == LAUNCH && addr_ok) begin
                m_start = 1'b1;
            end
            if (state == LAUNCH || state == WAIT) begin
                m_saddr = saddr_q;
                m_wdata = wdata_q;
            end
            if (state == RESP) begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
        end
    end

    // State, latched request, completion timer and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            timer   <= '0;
            id_q    <= '0;
            saddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        id_q    <= win;
                        saddr_q <= win_saddr;
                        wdata_q <= win_wdata;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    if (!addr_ok) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        rdata_q <= m_rdata;
                        err_q   <= 1'b0;
                    end else if (timer_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    ptr <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the single SPI master engine.
REQ-002 Parameter DWIDTH, default 32: transfer data width in bits.
REQ-003 Parameter NSLAVES, default 4: number of addressable SPI slaves.
REQ-004 Parameter S_ADDR_WIDTH, default $clog2(NSLAVES): slave address width.
REQ-005 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for master completion.
REQ-006 clk  in  1: the single clock; all logic is on the rising edge.
REQ-007 rst  in  1: reset, synchronous and active-high.
REQ-008 req_valid  in  NREQ: per-requester transfer request.
REQ-009 req_saddr  in  NREQ*S_ADDR_WIDTH: per-requester target slave; requester i occupies slice i.
REQ-010 req_wdata  in  NREQ*DWIDTH: per-requester write data; requester i occupies slice i.
REQ-011 req_ready  out  NREQ: one-hot accept pulse.
REQ-012 m_start  out  1: one-cycle launch pulse to the SPI master.
REQ-013 m_saddr  out  S_ADDR_WIDTH: slave select address to the master.
REQ-014 m_wdata  out  DWIDTH: data to the master.
REQ-015 m_done  in  1: master completion pulse.
REQ-016 m_rdata  in  DWIDTH: master read data; valid when m_done=1.
REQ-017 rsp_valid  out  1: one-cycle response pulse.
REQ-018 rsp_id  out  $clog2(NREQ): index of the responding requester.
REQ-019 rsp_rdata  out  DWIDTH: returned read data.
REQ-020 rsp_err  out  1: error flag, qualified by rsp_valid.
REQ-021 busy  out  1: high whenever state is not IDLE.

Function
REQ-022 FSM states are IDLE, LAUNCH, WAIT and RESP, held in one registered state variable.
REQ-023 IDLE, no req_valid bit set: remain in IDLE; all pulse outputs are 0.
REQ-024 IDLE, any req_valid bit set: the winner is the first set bit scanning upward from ptr and wrapping modulo NREQ.
REQ-025 IDLE grant actions, in the same cycle: req_ready[winner]=1 (combinational); latch winner id, saddr and wdata; go to LAUNCH.
REQ-026 A requester holds valid, saddr and wdata until it sees ready; an accepted request is consumed in that cycle.
REQ-027 LAUNCH with latched saddr < NSLAVES: m_start=1 for exactly one cycle; reset the timer; go to WAIT.
REQ-028 LAUNCH with latched saddr >= NSLAVES: no m_start; go to RESP with err=1 and rdata=0.
REQ-029 m_saddr and m_wdata are registered and hold the latched values from LAUNCH through WAIT; they are 0 otherwise.
REQ-030 WAIT, m_done=1: latch m_rdata; err=0; go to RESP.
REQ-031 WAIT, m_done=0: the timer increments.
REQ-032 WAIT timeout: when the timer reaches TIMEOUT-1 without m_done, go to RESP with err=1 and rdata=0.
REQ-033 If m_done and timeout occur in the same cycle, m_done wins (err=0).
REQ-034 m_done is ignored in IDLE, LAUNCH and RESP.
REQ-035 Timer width is $clog2(TIMEOUT+1); the timer saturates and never wraps.
REQ-036 RESP: rsp_valid=1 for one cycle with registered rsp_id, rsp_rdata and rsp_err; set ptr to (id+1) mod NREQ; go to IDLE.
REQ-037 rsp_id, rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
REQ-038 Latency for a normal transfer:
- ready at cycle 0;
- m_start at cycle 1;
- m_done at cycle k, with k >= 2;
- rsp_valid at cycle k+1.
REQ-039 Minimum spacing between grants is 4 cycles (m_done at cycle 2).
REQ-040 New requests arriving outside IDLE are not acknowledged and wait for the next IDLE.

Reset
REQ-041 While rst=1 at an edge: state=IDLE, ptr=0, timer=0, latches=0.
REQ-042 While rst=1, all outputs are 0: req_ready=0, m_start=0, m_saddr=0, m_wdata=0, rsp_*=0, busy=0.
REQ-043 Reset mid-transfer (any state): abort to IDLE with no rsp_valid; a later m_done is ignored.
REQ-044 Grants resume in the first cycle after rst deasserts.

Verification
REQ-045 Single transfer:
- stimulus: req_valid=4'b0100, saddr2=1, wdata2=0xA5A5_0001, m_done at cycle 5 with m_rdata=0x1234_5678;
- required: ready=4'b0100 at cycle 0; m_start, m_saddr=1, m_wdata=0xA5A5_0001 at cycle 1; rsp at cycle 6 with id=2, rdata=0x1234_5678, err=0.
REQ-046 Round-robin:
- stimulus: req_valid=4'b1111 held constant, master completing immediately;
- required: grant order 0,1,2,3,0; ptr=1 after the first response.
REQ-047 Timeout:
- stimulus: TIMEOUT=8, m_done never asserted;
- required: rsp_valid with err=1 and rdata=0 at cycle 9 after m_start.
- stimulus: m_done asserted on the timeout cycle;
- required: err=0.
REQ-048 Bad address:
- stimulus: NSLAVES=3, saddr=3;
- required: no m_start; rsp_valid at cycle 2 with err=1.
REQ-049 Reset in WAIT:
- stimulus: assert rst for one cycle during WAIT, then pulse m_done;
- required: no rsp_valid; next request granted with ptr=0 priority.
